// File: rtl/regfile_scb_if.sv
// Register-file bus: two read ports with scoreboard status, one write port,
// an issue-time pending-set port and the init-done flag.
interface regfile_scb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rs1_read_o;
  logic [XLEN-1:0] rs2_read_o;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] write_data_in;
  logic            reg_write;
  logic            busy_set;
  logic [AW-1:0]   busy_rd;
  logic            rs1_busy_o;
  logic            rs2_busy_o;
  logic            init_done_o;

  modport master (
    output rs1, rs2, rd, write_data_in, reg_write, busy_set, busy_rd,
    input  rs1_read_o, rs2_read_o, rs1_busy_o, rs2_busy_o, init_done_o
  );

  modport slave (
    input  rs1, rs2, rd, write_data_in, reg_write, busy_set, busy_rd,
    output rs1_read_o, rs2_read_o, rs1_busy_o, rs2_busy_o, init_done_o
  );
endinterface

// File: rtl/regfile_scb.sv
// Two-read/one-write register file with a post-reset clear sequencer and a
// per-register pending bit. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module regfile_scb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_scb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]      state;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic            run;
  logic            wr_en;
  logic            set_en;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign run    = (state == ST_RUN);
  assign wr_en  = run && bus.reg_write && !is_zero_reg(bus.rd);
  assign set_en = run && bus.busy_set && !is_zero_reg(bus.busy_rd);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en)        set_mask[bus.busy_rd] = 1'b1;
    if (run && bus.reg_write) clr_mask[bus.rd] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_idx <= '0;
      pending <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == AW'(NREGS - 1)) state <= ST_RUN;
        end
        ST_RUN: begin
          // Set is ORed in last so a new issue overrides an older writeback.
          pending <= (pending & ~clr_mask) | set_mask;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the INIT sequencer clears it one
  // entry per cycle so it maps onto plain RAM/flop arrays without a reset net.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) regs[clr_idx] <= '0;
      else if (wr_en)       regs[bus.rd]  <= bus.write_data_in;
    end
  end

  assign bus.init_done_o = run;

  function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] a);
    if (!run || is_zero_reg(a)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (bus.rd == a)) return bus.write_data_in;
`endif
    return regs[a];
  endfunction

  function automatic logic read_busy(input logic [AW-1:0] a);
    if (!run || is_zero_reg(a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (bus.rd == a)) return set_en && (bus.busy_rd == a);
`endif
    return pending[a];
  endfunction

  // NOTE: every output below is fully assigned on every path, so no latch
  // can be inferred from the combinational read logic.
  always_comb begin
    bus.rs1_read_o = read_data(bus.rs1);
    bus.rs2_read_o = read_data(bus.rs2);
    bus.rs1_busy_o = read_busy(bus.rs1);
    bus.rs2_busy_o = read_busy(bus.rs2);
  end
endmodule

// File: tb/tb_regfile_scb.sv
// Directed self-checking bench for regfile_scb: init sequencing, reset during
// INIT, write/read, x0 handling, scoreboard set/clear/collision and bypass.
module tb_regfile_scb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_scb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  regfile_scb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.reg_write     = 1'b0;
    bus.busy_set      = 1'b0;
    bus.rd            = '0;
    bus.busy_rd       = '0;
    bus.write_data_in = '0;
  endtask

  initial begin
    idle();
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;

    // Reset held three cycles
    repeat (3) tick();
    check("rst_init_done", 32'(bus.init_done_o), 32'd0);
    check("rst_rs1_busy",  32'(bus.rs1_busy_o),  32'd0);
    check("rst_rs1_read",  bus.rs1_read_o,       32'd0);

    // Release, run 10 INIT cycles, then reset again for one cycle
    rst = 1'b0;
    repeat (10) tick();
    check("mid_init_done", 32'(bus.init_done_o), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Traffic during INIT must be ignored; init_done rises at edge 32
    bus.reg_write     = 1'b1;
    bus.rd            = 5'd5;
    bus.write_data_in = 32'hFFFF_0000;
    bus.busy_set      = 1'b1;
    bus.busy_rd       = 5'd7;
    bus.rs1           = 5'd5;
    bus.rs2           = 5'd7;
    for (int k = 1; k <= NREGS; k++) begin
      tick();
      check($sformatf("init_done_c%0d", k), 32'(bus.init_done_o), (k == NREGS) ? 32'd1 : 32'd0);
      if (k < NREGS) begin
        check($sformatf("init_rd_c%0d", k),   bus.rs1_read_o,      32'd0);
        check($sformatf("init_busy_c%0d", k), 32'(bus.rs2_busy_o), 32'd0);
      end
    end
    idle();
    #1;

    // Every register cleared, nothing pending
    for (int i = 0; i < NREGS; i++) begin
      bus.rs1 = 5'(i);
      bus.rs2 = 5'(i);
      #1;
      check($sformatf("clr_r%0d", i),  bus.rs1_read_o,      32'd0);
      check($sformatf("clr_b%0d", i),  32'(bus.rs2_busy_o), 32'd0);
    end

    // Plain write/read
    bus.reg_write = 1'b1; bus.rd = 5'd5; bus.write_data_in = 32'hDEAD_BEEF;
    tick();
    idle();
    bus.rs1 = 5'd5; bus.rs2 = 5'd0;
    #1;
    check("wr5_rs1", bus.rs1_read_o, 32'hDEAD_BEEF);
    check("wr5_rs2", bus.rs2_read_o, 32'd0);

    // x0 write dropped, x0 never pending
    bus.reg_write = 1'b1; bus.rd = 5'd0; bus.write_data_in = 32'h1234;
    bus.busy_set  = 1'b1; bus.busy_rd = 5'd0;
    tick();
    idle();
    bus.rs1 = 5'd0;
    #1;
    check("x0_read", bus.rs1_read_o,      32'd0);
    check("x0_busy", 32'(bus.rs1_busy_o), 32'd0);

    // Scoreboard set then cleared by writeback
    bus.busy_set = 1'b1; bus.busy_rd = 5'd7;
    tick();
    idle();
    bus.rs2 = 5'd7;
    #1;
    check("sb7_busy", 32'(bus.rs2_busy_o), 32'd1);
    bus.reg_write = 1'b1; bus.rd = 5'd7; bus.write_data_in = 32'h55;
    tick();
    idle();
    #1;
    check("sb7_clear", 32'(bus.rs2_busy_o), 32'd0);
    check("sb7_data",  bus.rs2_read_o,      32'h55);

    // Same-index set and clear: set wins, data written
    bus.busy_set  = 1'b1; bus.busy_rd = 5'd9;
    bus.reg_write = 1'b1; bus.rd = 5'd9; bus.write_data_in = 32'h99;
    tick();
    idle();
    bus.rs1 = 5'd9;
    #1;
    check("col9_busy", 32'(bus.rs1_busy_o), 32'd1);
    check("col9_data", bus.rs1_read_o,      32'h99);

    // Different indices: clear 9 and set 10 together
    bus.busy_set  = 1'b1; bus.busy_rd = 5'd10;
    bus.reg_write = 1'b1; bus.rd = 5'd9; bus.write_data_in = 32'h77;
    tick();
    idle();
    bus.rs1 = 5'd9; bus.rs2 = 5'd10;
    #1;
    check("diff9_busy",  32'(bus.rs1_busy_o), 32'd0);
    check("diff9_data",  bus.rs1_read_o,      32'h77);
    check("diff10_busy", 32'(bus.rs2_busy_o), 32'd1);

    // Same-cycle read of a register being written back
    bus.busy_set = 1'b1; bus.busy_rd = 5'd3;
    tick();
    idle();
    bus.rs1 = 5'd3;
    bus.reg_write = 1'b1; bus.rd = 5'd3; bus.write_data_in = 32'hA5A5_A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_read", bus.rs1_read_o,      32'hA5A5_A5A5);
    check("byp_busy", 32'(bus.rs1_busy_o), 32'd0);
`else
    check("byp_read", bus.rs1_read_o,      32'd0);
    check("byp_busy", 32'(bus.rs1_busy_o), 32'd1);
`endif
    tick();
    idle();
    #1;
    check("post3_read", bus.rs1_read_o,      32'hA5A5_A5A5);
    check("post3_busy", 32'(bus.rs1_busy_o), 32'd0);

    // Reset during RUN restarts the clear and drops pending bits
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rerun_done", 32'(bus.init_done_o), 32'd0);
    repeat (NREGS) tick();
    bus.rs1 = 5'd10; bus.rs2 = 5'd3;
    #1;
    check("rerun_done2", 32'(bus.init_done_o), 32'd1);
    check("rerun_busy",  32'(bus.rs1_busy_o),  32'd0);
    check("rerun_read",  bus.rs2_read_o,       32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_scb.md
Name: regfile_scb

Overview:
- Parametrised successor to the two-read/one-write CPU register file.
- Generalised in data width and register count.
- Adds a hardware init sequencer: array cleared to zero after reset without a reset net on the storage.
- Adds a per-register pending (scoreboard) bit so the multicycle control FSM can detect read-after-write hazards on in-flight writebacks.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, >= 2; address width AW = $clog2(NREGS), a derived localparam.
- ZERO_REG, 1, 1 = index 0 is hardwired zero (writes dropped, never pending); 0 = index 0 is an ordinary register.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1  input  AW  read address, port 1.
- rs2  input  AW  read address, port 2.
- rs1_read_o  output  XLEN  read data, port 1.
- rs2_read_o  output  XLEN  read data, port 2.
- rd  input  AW  write address.
- write_data_in  input  XLEN  write data.
- reg_write  input  1  write enable; also clears pending[rd].
- busy_set  input  1  marks busy_rd as pending (issue of an instruction with a destination).
- busy_rd  input  AW  register to mark pending.
- rs1_busy_o  output  1  pending[rs1].
- rs2_busy_o  output  1  pending[rs2].
- init_done_o  output  1  high once the array is cleared and the block accepts traffic.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst (fixed).
- States: INIT, RUN.
- Reset:
  - state <= INIT, clr_idx <= 0, init_done_o <= 0, all pending bits <= 0.
  - Reset asserted mid-INIT or mid-RUN restarts the clear at index 0.
- INIT:
  - Each cycle with rst low: regs[clr_idx] <= 0, clr_idx <= clr_idx + 1.
  - When clr_idx == NREGS-1: that entry is cleared, next state RUN, init_done_o <= 1.
  - INIT therefore lasts exactly NREGS cycles after rst deasserts; init_done_o rises on the edge ending cycle NREGS.
  - reg_write and busy_set are ignored (no storage or pending update).
  - rs1_read_o, rs2_read_o, rs1_busy_o and rs2_busy_o are forced to 0.
- RUN:
  - Reads are asynchronous (combinational from rs1/rs2 and array state).
  - If ZERO_REG=1 and the address is 0: read returns 0 and busy returns 0.
  - Write: if reg_write and !(ZERO_REG && rd==0), regs[rd] <= write_data_in at the edge; visible to reads the following cycle (no same-cycle bypass unless the optional feature is enabled).
  - Pending set: busy_set sets pending[busy_rd] (ignored for x0 when ZERO_REG).
  - Pending clear: reg_write clears pending[rd].
  - Simultaneous set and clear of the same index: set wins (a new issue overrides the older writeback).
  - Different indices: both take effect.
  - Pending bits do not gate writes; reg_write to a non-pending register still writes.
- Outputs after reset: init_done_o = 0, busy outputs = 0, read outputs = 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (RUN only; condition is reg_write, rd == rsN, and rd not hardwired zero):
  - rsN_read_o = write_data_in (write-through forwarding in the same cycle).
  - rsN_busy_o = 0 unless busy_set targets the same index in that cycle.
- Undefined: reads return the array contents and pending bit as held before the edge; a same-cycle write is seen next cycle.
- Pending-bit state update is identical in both builds; only the outputs differ.

Test Plan:
- Init:
  - Stimulus: NREGS=32; hold rst 3 cycles, release.
  - Required: init_done_o low for 32 cycles then high; all 32 registers read 0; busy outputs 0 throughout.
- Write/read:
  - Stimulus: reg_write rd=5 data=0xDEADBEEF; next cycle rs1=5, rs2=0.
  - Required: rs1_read_o=0xDEADBEEF, rs2_read_o=0.
  - Stimulus: write rd=0 data=0x1234.
  - Required: rs1=0 still reads 0.
- Scoreboard:
  - Stimulus: busy_set busy_rd=7; next cycle rs2=7.
  - Required: rs2_busy_o=1.
  - Stimulus: reg_write rd=7 data=0x55.
  - Required: next cycle rs2_busy_o=0, rs2_read_o=0x55.
- Collision:
  - Stimulus: same cycle busy_set busy_rd=9 and reg_write rd=9.
  - Required: pending[9]=1 afterwards; regs[9] holds the written data.
- Reset mid-INIT:
  - Stimulus: after 10 INIT cycles assert rst 1 cycle, release.
  - Required: init_done_o rises exactly 32 cycles after release.
  - Stimulus: writes and busy_set during INIT.
  - Required: no effect.
- Bypass (REGFILE_BYPASS_EN):
  - Stimulus: pending[3]=1; reg_write rd=3 data=0xA5A5A5A5 with rs1=3.
  - Required: same cycle rs1_read_o=0xA5A5A5A5, rs1_busy_o=0.
  - Without the macro: old value and busy=1 in that cycle.
